// File: rtl/trivius_pkg.sv
// Shared definitions for the parametrised I2S transmitter.
//   i2s_mode_e   : frame format (Philips, left-justified, right-justified)
//   SLOT_MAX     : widest channel slot the frame builder supports
//   justify_slot : places one sample inside its channel slot
package trivius_pkg;

    typedef enum logic [1:0] {
        I2S_PHILIPS = 2'd0,
        I2S_LEFT_J  = 2'd1,
        I2S_RIGHT_J = 2'd2
    } i2s_mode_e;

    localparam int unsigned SLOT_MAX   = 64;
    localparam int unsigned SLOT_IDX_W = $clog2(SLOT_MAX);

    // Returns a SLOT_MAX-wide vector whose low slot_w bits are the slot
    // contents, MSB first on the wire. Philips/left-justified put the sample
    // in the slot MSBs and zero-pad below; right-justified puts it in the
    // slot LSBs and sign-extends above. Bits at and above slot_w stay zero.
    function automatic logic [SLOT_MAX-1:0] justify_slot(
        input logic [SLOT_MAX-1:0] sample,
        input int unsigned         sample_w,
        input int unsigned         slot_w,
        input i2s_mode_e           mode
    );
        logic [SLOT_MAX-1:0] slot;
        int unsigned         pad;
        slot = '0;
        pad  = slot_w - sample_w;
        for (int unsigned i = 0; i < SLOT_MAX; i++) begin
            if (i < slot_w) begin
                if (mode == I2S_RIGHT_J) begin
                    slot[i] = (i < sample_w) ? sample[SLOT_IDX_W'(i)]
                                             : sample[SLOT_IDX_W'(sample_w - 1)];
                end else if (i >= pad) begin
                    slot[i] = sample[SLOT_IDX_W'(i - pad)];
                end
            end
        end
        return slot;
    endfunction

endpackage

// File: rtl/i2s_bclk_div.sv
// Bit-clock divider for the I2S transmitter.
//   i_aud_clk     : audio clock
//   i_aud_reset_n : asynchronous active-low reset
//   o_bclk        : registered bit clock, BCLK_DIV aud_clk cycles per period
//   o_rise        : high in the cycle before o_bclk goes high
//   o_fall        : high in the cycle before o_bclk goes low
module i2s_bclk_div #(
    parameter int unsigned BCLK_DIV = 2
) (
    input  logic i_aud_clk,
    input  logic i_aud_reset_n,
    output logic o_bclk,
    output logic o_rise,
    output logic o_fall
);

    if (BCLK_DIV < 2) begin : g_err_div_small
        $fatal(1, "BCLK_DIV must be >= 2");
    end
    if ((BCLK_DIV % 2) != 0) begin : g_err_div_odd
        $fatal(1, "BCLK_DIV must be even");
    end

    localparam int unsigned      DIV_W   = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] RISE_AT = DIV_W'(BCLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] FALL_AT = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_comb begin
        o_rise = (div_cnt == RISE_AT);
        o_fall = (div_cnt == FALL_AT);
    end

    always_ff @(posedge i_aud_clk or negedge i_aud_reset_n) begin
        if (!i_aud_reset_n) begin
            div_cnt <= '0;
            o_bclk  <= 1'b0;
        end else begin
            div_cnt <= o_fall ? '0 : div_cnt + DIV_W'(1);
            if (o_rise) begin
                o_bclk <= 1'b1;
            end else if (o_fall) begin
                o_bclk <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/i2s_tx_param.sv
// Parametrised I2S master transmitter with a one-deep sample holding register.
//   i_aud_clk     : audio clock (only clock)
//   i_aud_reset_n : asynchronous active-low reset
//   i_left/i_right: two's complement sample pair, SAMPLE_W bits each
//   i_valid       : writes the pair into the holding register this cycle
//   o_bclk        : bit clock
//   o_ws          : word select, 0 = left slot, 1 = right slot
//   o_sda         : serial data, MSB first, changes with the BCLK fall
//   o_req         : one-cycle pulse after each frame load
//   o_underrun    : one-cycle pulse when a frame loads with no data available
module i2s_tx_param
    import trivius_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned SLOT_W   = 16,
    parameter int unsigned BCLK_DIV = 2,
    parameter i2s_mode_e   MODE     = I2S_PHILIPS
) (
    input  logic                i_aud_clk,
    input  logic                i_aud_reset_n,
    input  logic [SAMPLE_W-1:0] i_left,
    input  logic [SAMPLE_W-1:0] i_right,
    input  logic                i_valid,
    output logic                o_bclk,
    output logic                o_ws,
    output logic                o_sda,
    output logic                o_req,
    output logic                o_underrun
);

    if (SLOT_W < SAMPLE_W) begin : g_err_slot
        $fatal(1, "SLOT_W must be >= SAMPLE_W");
    end
    if (SLOT_W > SLOT_MAX) begin : g_err_slot_max
        $fatal(1, "SLOT_W exceeds SLOT_MAX");
    end
    if (SAMPLE_W < 1) begin : g_err_sample
        $fatal(1, "SAMPLE_W must be >= 1");
    end

    localparam int unsigned      FRAME_W   = 2 * SLOT_W;
    localparam int unsigned      BIT_W     = $clog2(FRAME_W);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] WS_SWITCH = BIT_W'(SLOT_W);

    logic bclk_fall;
    logic bclk_rise_unused;

    i2s_bclk_div #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_div (
        .i_aud_clk     (i_aud_clk),
        .i_aud_reset_n (i_aud_reset_n),
        .o_bclk        (o_bclk),
        .o_rise        (bclk_rise_unused),
        .o_fall        (bclk_fall)
    );

    logic [BIT_W-1:0]    bit_cnt;
    logic [FRAME_W-1:0]  shift_q;
    logic                philips_dly_q;
    logic                hold_full_q;
    logic [SAMPLE_W-1:0] hold_left_q;
    logic [SAMPLE_W-1:0] hold_right_q;

    logic                load;
    logic                starved;
    logic [BIT_W-1:0]    bit_nxt;
    logic [SAMPLE_W-1:0] src_left;
    logic [SAMPLE_W-1:0] src_right;
    logic [SLOT_MAX-1:0] left_ext;
    logic [SLOT_MAX-1:0] right_ext;
    logic [SLOT_MAX-1:0] left_slot;
    logic [SLOT_MAX-1:0] right_slot;
    logic [FRAME_W-1:0]  new_frame;
    logic                ser_bit;
    logic                unused_slot_bits;

    always_comb begin
        load    = bclk_fall && (bit_cnt == BIT_LAST);
        starved = !i_valid && !hold_full_q;
        bit_nxt = load ? '0 : bit_cnt + BIT_W'(1);

        // A write in the load cycle bypasses the holding register.
        src_left  = '0;
        src_right = '0;
        if (i_valid) begin
            src_left  = i_left;
            src_right = i_right;
        end else if (hold_full_q) begin
            src_left  = hold_left_q;
            src_right = hold_right_q;
        end

        left_ext                  = '0;
        right_ext                 = '0;
        left_ext[SAMPLE_W-1:0]    = src_left;
        right_ext[SAMPLE_W-1:0]   = src_right;
        left_slot                 = justify_slot(left_ext,  SAMPLE_W, SLOT_W, MODE);
        right_slot                = justify_slot(right_ext, SAMPLE_W, SLOT_W, MODE);
        new_frame                 = starved ? '0
                                            : {left_slot[SLOT_W-1:0], right_slot[SLOT_W-1:0]};

        // The frame MSB goes out on the load edge itself; the shift register
        // holds the remaining bits left-aligned.
        ser_bit = load ? new_frame[FRAME_W-1] : shift_q[FRAME_W-1];

        unused_slot_bits = ^{left_slot, right_slot};
    end

    always_ff @(posedge i_aud_clk or negedge i_aud_reset_n) begin
        if (!i_aud_reset_n) begin
            bit_cnt       <= BIT_LAST;
            shift_q       <= '0;
            philips_dly_q <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_left_q   <= '0;
            hold_right_q  <= '0;
            o_ws          <= 1'b1;
            o_sda         <= 1'b0;
            o_req         <= 1'b0;
            o_underrun    <= 1'b0;
        end else begin
            o_req      <= load;
            o_underrun <= load && starved;

            if (bclk_fall) begin
                bit_cnt <= bit_nxt;
                o_ws    <= (bit_nxt >= WS_SWITCH);
                if (load) begin
                    shift_q <= {new_frame[FRAME_W-2:0], 1'b0};
                end else begin
                    shift_q <= {shift_q[FRAME_W-2:0], 1'b0};
                end
                // Philips: one extra BCLK of delay, so the last right-slot bit
                // of a frame is emitted at bit_cnt 0 of the next one.
                philips_dly_q <= ser_bit;
                o_sda         <= (MODE == I2S_PHILIPS) ? philips_dly_q : ser_bit;
            end

            if (load) begin
                hold_full_q <= 1'b0;
            end else if (i_valid) begin
                hold_full_q  <= 1'b1;
                hold_left_q  <= i_left;
                hold_right_q <= i_right;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_param.sv
// Directed bench for i2s_tx_param: Philips and left-justified instances share
// stimulus (SLOT_W=16), a right-justified instance uses SLOT_W=24.
module tb_i2s_tx_param;
    import trivius_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] left, right, left_r, right_r;
    logic        valid, valid_r;

    logic l_bclk, l_ws, l_sda, l_req, l_und;
    logic p_bclk, p_ws, p_sda, p_req, p_und;
    logic r_bclk, r_ws, r_sda, r_req, r_und;

    int cyc = -1;
    int checks = 0;
    int errors = 0;

    logic l_sda_log [0:511];
    logic p_sda_log [0:511];
    logic r_sda_log [0:511];
    logic ws_log    [0:511];
    logic bclk_log  [0:511];
    logic req_log   [0:511];
    logic und_log   [0:511];
    logic r_und_log [0:511];

    always #5 clk = ~clk;

    i2s_tx_param #(.SAMPLE_W(16), .SLOT_W(16), .BCLK_DIV(2), .MODE(I2S_LEFT_J)) dut_l (
        .i_aud_clk(clk), .i_aud_reset_n(rst_n), .i_left(left), .i_right(right),
        .i_valid(valid), .o_bclk(l_bclk), .o_ws(l_ws), .o_sda(l_sda),
        .o_req(l_req), .o_underrun(l_und));

    i2s_tx_param #(.SAMPLE_W(16), .SLOT_W(16), .BCLK_DIV(2), .MODE(I2S_PHILIPS)) dut_p (
        .i_aud_clk(clk), .i_aud_reset_n(rst_n), .i_left(left), .i_right(right),
        .i_valid(valid), .o_bclk(p_bclk), .o_ws(p_ws), .o_sda(p_sda),
        .o_req(p_req), .o_underrun(p_und));

    i2s_tx_param #(.SAMPLE_W(16), .SLOT_W(24), .BCLK_DIV(2), .MODE(I2S_RIGHT_J)) dut_r (
        .i_aud_clk(clk), .i_aud_reset_n(rst_n), .i_left(left_r), .i_right(right_r),
        .i_valid(valid_r), .o_bclk(r_bclk), .o_ws(r_ws), .o_sda(r_sda),
        .o_req(r_req), .o_underrun(r_und));

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one aud_clk cycle and record outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= 0 && cyc < 512) begin
            l_sda_log[cyc] = l_sda;
            p_sda_log[cyc] = p_sda;
            r_sda_log[cyc] = r_sda;
            ws_log[cyc]    = l_ws;
            bclk_log[cyc]  = l_bclk;
            req_log[cyc]   = l_req;
            und_log[cyc]   = l_und;
            r_und_log[cyc] = r_und;
        end
    endtask

    // Collect n serial bits presented every 2 cycles from cycle 'start', first bit in MSB.
    function automatic logic [47:0] get_bits(input int sel, input int start, input int n);
        logic [47:0] w;
        logic        b;
        w = '0;
        for (int k = 0; k < n; k++) begin
            case (sel)
                0:       b = l_sda_log[start + 2 * k];
                1:       b = p_sda_log[start + 2 * k];
                2:       b = r_sda_log[start + 2 * k];
                default: b = ws_log[start + 2 * k];
            endcase
            w = {w[46:0], b};
        end
        return w;
    endfunction

    initial begin
        int bad;
        rst_n = 1'b0; valid = 1'b0; left = '0; right = '0;
        valid_r = 1'b0; left_r = '0; right_r = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs_l", {43'd0, l_bclk, l_ws, l_sda, l_req, l_und}, 48'b01000);
        check("rst_outputs_r", {45'd0, r_bclk, r_ws, p_sda}, 48'b010);

        @(negedge clk);
        rst_n = 1'b1;
        cyc = -1;
        while (cyc < 10) tick();
        valid = 1'b1;   left = 16'hA5F0;   right = 16'h0F0F;
        valid_r = 1'b1; left_r = 16'h8001; right_r = 16'h1234;
        tick();
        valid = 1'b0; valid_r = 1'b0;
        while (cyc < 192) tick();
        valid = 1'b1; left = 16'h1234; right = 16'h00FF;
        tick();
        valid = 1'b0;
        while (cyc < 200) tick();
        valid = 1'b1; left = 16'h5678; right = 16'h1111;
        tick();
        valid = 1'b0;
        while (cyc < 210) tick();
        valid = 1'b1; left = 16'h9ABC; right = 16'h2222;
        tick();
        valid = 1'b0;
        while (cyc < 361) tick();

        // Idle first frame: load at cycle 1, underrun, silent data, BCLK period 2.
        check("first_load_req_und", {46'd0, req_log[0], req_log[1]}, 48'b01);
        check("first_underrun", {47'd0, und_log[1]}, 48'd1);
        bad = 0;
        for (int c = 2; c <= 64; c++) if (req_log[c] !== 1'b0) bad++;
        check("req_single_pulse", 48'(bad), 48'd0);
        check("idle_sda_lj", get_bits(0, 1, 32), 48'd0);
        check("idle_sda_philips", get_bits(1, 1, 32), 48'd0);
        bad = 0;
        for (int c = 0; c < 64; c++) if (bclk_log[c] !== ((c % 2) == 0)) bad++;
        check("bclk_period", 48'(bad), 48'd0);
        check("ws_period", {43'd0, ws_log[0], ws_log[32], ws_log[33], ws_log[64], ws_log[65]}, 48'b10110);

        // Second frame carries the held pair.
        check("frameB_req_und", {46'd0, req_log[65], und_log[65]}, 48'b10);
        check("frameB_lj_data", get_bits(0, 65, 32), 48'h0000_A5F0_0F0F);
        check("frameB_ws", get_bits(3, 65, 32), 48'h0000_0000_FFFF);
        check("frameB_philips_data", get_bits(1, 65, 32), 48'h0000_52F8_0787);
        check("philips_right_lsb_next_frame", {47'd0, p_sda_log[129]}, 48'd1);
        check("frameC_underrun", {47'd0, und_log[129]}, 48'd1);
        check("frameC_lj_zero", get_bits(0, 129, 32), 48'd0);

        // Right-justified, 24-bit slot, sign extension.
        check("rj_first_underrun", {47'd0, r_und_log[1]}, 48'd1);
        check("rj_no_underrun", {47'd0, r_und_log[97]}, 48'd0);
        check("rj_frame_data", get_bits(2, 97, 48), 48'hFF8001_001234);

        // Bypass on the load cycle, then last-write-wins.
        check("bypass_req_und", {46'd0, req_log[193], und_log[193]}, 48'b10);
        check("bypass_frame", get_bits(0, 193, 32), 48'h0000_1234_00FF);
        check("overwrite_und", {47'd0, und_log[257]}, 48'd0);
        check("overwrite_frame", get_bits(0, 257, 32), 48'h0000_9ABC_2222);

        // Reset at bit_cnt=20 of the frame loaded at cycle 321.
        check("midframe_pre_ws_bclk", {46'd0, ws_log[361], bclk_log[361]}, 48'b10);
        rst_n = 1'b0;
        #1;
        check("midframe_rst_l", {43'd0, l_bclk, l_ws, l_sda, l_req, l_und}, 48'b01000);
        check("midframe_rst_pr", {45'd0, p_sda, r_ws, r_bclk}, 48'b010);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = -1;
        tick();
        tick();
        tick();
        check("restart_c0", {45'd0, bclk_log[0], ws_log[0], req_log[0]}, 48'b110);
        check("restart_load", {45'd0, req_log[1], und_log[1], ws_log[1]}, 48'b110);
        check("restart_c2", {46'd0, req_log[2], bclk_log[2]}, 48'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_tx_param.md
Name: i2s_tx_param

Overview:
- Parametrised successor to the fixed 16-bit Philips I2S master. Adds configurable sample and slot width, BCLK divider and justification mode, plus a one-deep sample holding register with valid handshake and underrun reporting.
- Sits in the audio clock domain between the voice/mixer output and the DAC pins.

Parameters:
- SAMPLE_W, 16: sample bits per channel.
- SLOT_W, 16: BCLK periods per channel slot. Must be >= SAMPLE_W.
- BCLK_DIV, 2: aud_clk cycles per BCLK period. Must be even and >= 2.
- MODE, I2S_PHILIPS: frame format. Values: I2S_PHILIPS, I2S_LEFT_J, I2S_RIGHT_J.

Ports:
- i_aud_clk, in, 1: audio clock. This is the only clock.
- i_aud_reset_n, in, 1: reset, asynchronous and active-low.
- i_left, in, SAMPLE_W: left sample, two's complement.
- i_right, in, SAMPLE_W: right sample, two's complement.
- i_valid, in, 1: writes i_left/i_right into the holding register this cycle.
- o_bclk, out, 1: bit clock, registered level.
- o_ws, out, 1: word select. 0 = left, 1 = right.
- o_sda, out, 1: serial data, MSB first.
- o_req, out, 1: one-cycle pulse requesting the next sample pair.
- o_underrun, out, 1: one-cycle pulse when a frame loads with the holding register empty.

Behaviour:
- Elaboration:
  - SLOT_W < SAMPLE_W is a fatal error.
  - Odd BCLK_DIV is a fatal error.
  - BCLK_DIV < 2 is a fatal error.
- Reset values (async assert, sync release):
  - o_bclk=0, o_ws=1, o_sda=0, o_req=0, o_underrun=0.
  - div_cnt=0, bit_cnt=2*SLOT_W-1.
  - Holding register empty, data zero. Frame shift register zero. Philips delay bit zero.
- BCLK generation:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - Rise event when div_cnt==BCLK_DIV/2-1: o_bclk<=1 next cycle.
  - Fall event when div_cnt==BCLK_DIV-1: o_bclk<=0 next cycle.
- Fall event actions:
  - bit_cnt advances modulo 2*SLOT_W.
  - o_ws and o_sda update on the same edge as o_bclk falls, so data is stable at the BCLK rise.
- Frame load, on the fall event where bit_cnt wraps to 0:
  - Build a 2*SLOT_W frame: left slot first, then right slot.
  - I2S_PHILIPS and I2S_LEFT_J: each sample occupies the slot MSBs; the remaining bits are zero.
  - I2S_RIGHT_J: each sample occupies the slot LSBs; the upper bits are sign-extended.
  - The frame source is the holding register if full. If i_valid is high in the load cycle, i_left/i_right are used directly (bypass).
  - If the holding register is empty and i_valid is low: load an all-zero frame and assert o_underrun in the next cycle.
  - The holding register becomes empty. o_req pulses in the next cycle.
  - o_ws=0 for bit_cnt 0..SLOT_W-1 and 1 for SLOT_W..2*SLOT_W-1.
- Serial data:
  - I2S_LEFT_J and I2S_RIGHT_J: o_sda = frame bit (2*SLOT_W-1-bit_cnt).
  - I2S_PHILIPS: o_sda is delayed one BCLK via the delay register, so the left MSB appears at bit_cnt=1. The right-slot LSB appears at bit_cnt=0 of the following frame.
- Holding register:
  - i_valid outside the load cycle overwrites the holding register (last write wins) and marks it full.
  - i_valid while full is not an error; it overwrites.
  - Upstream must respond to o_req within 2*SLOT_W*BCLK_DIV-1 cycles.
- Frame timing:
  - First frame load occurs BCLK_DIV-1 cycles after reset release.
  - Frame period is 2*SLOT_W*BCLK_DIV cycles.
- Reset mid-frame: all state returns to reset values immediately. The frame restarts from the reset timing and the partially sent frame is abandoned.

Decomposition:
- Package trivius_pkg:
  - Enum i2s_mode_e (I2S_PHILIPS, I2S_LEFT_J, I2S_RIGHT_J).
  - Function for frame assembly (justify + pad).
- Sub-module i2s_bclk_div:
  - Parameter BCLK_DIV.
  - Outputs o_bclk, o_rise, o_fall.
  - Holds div_cnt and the rise/fall events.

Test Plan:
- Reset release, no i_valid -> first load at cycle BCLK_DIV-1. o_underrun and o_req pulse once per frame. o_sda=0 throughout. With BCLK_DIV=2, SLOT_W=16: o_bclk toggles with period 2 and o_ws period is 64 cycles.
- I2S_LEFT_J, SAMPLE_W=SLOT_W=16, left=16'hA5F0, right=16'h0F0F written after o_req -> next frame o_sda serialises A5F0 while o_ws=0, then 0F0F while o_ws=1. No underrun.
- I2S_PHILIPS, same data -> left MSB 1 at bit_cnt=1. Right LSB 1 appears at bit_cnt=0 of the following frame.
- I2S_RIGHT_J, SAMPLE_W=16, SLOT_W=24, left=16'h8001 -> slot bits are FF8001 (sign-extended).
- i_valid coincident with the load cycle, left=16'h1234 -> frame carries 1234 via bypass, no underrun. A second i_valid mid-frame with 16'h5678 then 16'h9ABC -> next frame carries 9ABC.
- Assert i_aud_reset_n low at bit_cnt=20 -> outputs immediately take reset values. After release, the first load occurs again at BCLK_DIV-1 cycles.
